// File: rtl/bpu_table_ctrl_if.sv
`default_nettype none
// ============================================================================
// bpu_table_ctrl_if : control/update/write bus of the BPU table controller
// Revision: 1.0
// ============================================================================
interface bpu_table_ctrl_if #(
  parameter int IDX_W = 9,
  parameter int PC_W  = 32,
  parameter int TAG_W = PC_W - IDX_W - 2
);
  logic             flush_req;
  logic             busy;

  logic             cnt_push;
  logic [IDX_W-1:0] cnt_idx;
  logic [1:0]       cnt_prev;
  logic             cnt_taken;
  logic             cnt_ovf;

  logic             tgt_valid;
  logic             tgt_ready;
  logic [IDX_W-1:0] tgt_idx;
  logic [PC_W-1:0]  tgt_addr;
  logic [TAG_W-1:0] tgt_tag;

  logic             wr_tgt_en;
  logic             wr_cnt_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [PC_W-1:0]  wr_npc;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_cnt;

  // Master is the update/resolution side; slave is the table controller.
  modport master (
    output flush_req, cnt_push, cnt_idx, cnt_prev, cnt_taken,
           tgt_valid, tgt_idx, tgt_addr, tgt_tag,
    input  busy, cnt_ovf, tgt_ready,
           wr_tgt_en, wr_cnt_en, wr_idx, wr_valid, wr_npc, wr_tag, wr_cnt
  );

  modport slave (
    input  flush_req, cnt_push, cnt_idx, cnt_prev, cnt_taken,
           tgt_valid, tgt_idx, tgt_addr, tgt_tag,
    output busy, cnt_ovf, tgt_ready,
           wr_tgt_en, wr_cnt_en, wr_idx, wr_valid, wr_npc, wr_tag, wr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bpu_table_ctrl.sv
`default_nettype none
// ============================================================================
// bpu_table_ctrl : BPU table write-port owner (init sweep, counter FIFO,
//                  target installs)
// Revision: 1.0
// ============================================================================
module bpu_table_ctrl #(
  parameter int TABLE_SIZE = 512,
  parameter int IDX_W      = 9,
  parameter int PC_W       = 32,
  parameter int TAG_W      = PC_W - IDX_W - 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            nrst,
  bpu_table_ctrl_if.slave tbl_if
);

  localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       prev;
    logic             taken;
  } cnt_ent_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d, sweep_cur;

  cnt_ent_t         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic             wr_tgt_en_q, wr_tgt_en_d;
  logic             wr_cnt_en_q, wr_cnt_en_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PC_W-1:0]  wr_npc_q, wr_npc_d;
  logic [TAG_W-1:0] wr_tag_q, wr_tag_d;
  logic [1:0]       wr_cnt_q, wr_cnt_d;

  logic             in_run;
  logic             tgt_rdy;
  logic             accept;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             fifo_empty;
  logic             fifo_full;
  cnt_ent_t         head;
  cnt_ent_t         incoming;

  function automatic logic [1:0] cnt_next(input logic [1:0] prev, input logic taken);
    if (taken && prev[1])
      return 2'b11;
    else if ((taken && prev == 2'b01) || (!taken && prev == 2'b11))
      return 2'b10;
    else if ((taken && prev == 2'b00) || (!taken && prev == 2'b10))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign in_run     = (state_q == RUN);
  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign incoming   = '{idx: tbl_if.cnt_idx, prev: tbl_if.cnt_prev, taken: tbl_if.cnt_taken};

  assign tgt_rdy = in_run && !tbl_if.flush_req;
  assign accept  = tgt_rdy && tbl_if.tgt_valid;
  // wr_idx is shared: a counter pop rides along only when its index matches the install.
  assign pop     = tgt_rdy && !fifo_empty && (!accept || (tbl_if.tgt_idx == head.idx));
  assign push_ok = tgt_rdy && tbl_if.cnt_push && (!fifo_full || pop);
  assign drop    = tgt_rdy && tbl_if.cnt_push && fifo_full && !pop;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q || drop;
    wr_tgt_en_d = 1'b0;
    wr_cnt_en_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_valid_d  = wr_valid_q;
    wr_npc_d    = wr_npc_q;
    wr_tag_d    = wr_tag_q;
    wr_cnt_d    = wr_cnt_q;
    sweep_cur   = tbl_if.flush_req ? '0 : sweep_idx_q;

    unique case (state_q)
      SWEEP: begin
        wr_tgt_en_d = 1'b1;
        wr_cnt_en_d = 1'b1;
        wr_idx_d    = sweep_cur;
        wr_valid_d  = 1'b0;
        wr_npc_d    = '0;
        wr_tag_d    = '0;
        wr_cnt_d    = 2'b01;
        sweep_idx_d = sweep_cur + IDX_W'(1);
        rd_ptr_d    = '0;
        wr_ptr_d    = '0;
        count_d     = '0;
        if (sweep_cur == LAST_IDX) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (tbl_if.flush_req) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
          busy_d      = 1'b1;
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
          count_d     = '0;
        end else begin
          if (pop) begin
            wr_cnt_en_d = 1'b1;
            wr_idx_d    = head.idx;
            wr_cnt_d    = cnt_next(head.prev, head.taken);
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          end
          if (accept) begin
            wr_tgt_en_d = 1'b1;
            wr_idx_d    = tbl_if.tgt_idx;
            wr_valid_d  = 1'b1;
            wr_npc_d    = tbl_if.tgt_addr;
            wr_tag_d    = tbl_if.tgt_tag;
          end
          if (push_ok)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b1;
      ovf_q       <= 1'b0;
      wr_tgt_en_q <= 1'b0;
      wr_cnt_en_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_npc_q    <= '0;
      wr_tag_q    <= '0;
      wr_cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      wr_tgt_en_q <= wr_tgt_en_d;
      wr_cnt_en_q <= wr_cnt_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_valid_q  <= wr_valid_d;
      wr_npc_q    <= wr_npc_d;
      wr_tag_q    <= wr_tag_d;
      wr_cnt_q    <= wr_cnt_d;
      if (push_ok)
        fifo_q[wr_ptr_q] <= incoming;
    end
  end

  assign tbl_if.busy      = busy_q;
  assign tbl_if.cnt_ovf   = ovf_q;
  assign tbl_if.tgt_ready = tgt_rdy;
  assign tbl_if.wr_tgt_en = wr_tgt_en_q;
  assign tbl_if.wr_cnt_en = wr_cnt_en_q;
  assign tbl_if.wr_idx    = wr_idx_q;
  assign tbl_if.wr_valid  = wr_valid_q;
  assign tbl_if.wr_npc    = wr_npc_q;
  assign tbl_if.wr_tag    = wr_tag_q;
  assign tbl_if.wr_cnt    = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bpu_table_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bpu_table_ctrl : scoreboard bench for bpu_table_ctrl
// Revision: 1.0
// ============================================================================
module tb_bpu_table_ctrl;

  localparam int TS = 512;
  localparam int IW = 9;
  localparam int PW = 32;
  localparam int TW = 21;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    int          c;
    bit          te;
    bit          ce;
    logic [IW-1:0] idx;
    bit          v;
    logic [PW-1:0] npc;
    logic [TW-1:0] tag;
    logic [1:0]  cn;
    bit          bz;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  bpu_table_ctrl_if #(.IDX_W(IW), .PC_W(PW), .TAG_W(TW)) bif ();

  bpu_table_ctrl #(
    .TABLE_SIZE(TS), .IDX_W(IW), .PC_W(PW), .TAG_W(TW), .FIFO_DEPTH(2)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .tbl_if (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // 2-bit saturating counter reference
  function automatic logic [1:0] cnt_ref(input logic [1:0] prev, input bit taken);
    logic [1:0] tk_tbl [4];
    logic [1:0] nt_tbl [4];
    tk_tbl = '{2'b01, 2'b10, 2'b11, 2'b11};
    nt_tbl = '{2'b00, 2'b00, 2'b01, 2'b10};
    return taken ? tk_tbl[prev] : nt_tbl[prev];
  endfunction

  function automatic void exp_push(input int c, input bit te, input bit ce,
                                   input logic [IW-1:0] idx, input bit v,
                                   input logic [PW-1:0] npc, input logic [TW-1:0] tag,
                                   input logic [1:0] cn, input bit bz);
    exp_t e;
    e.c = c; e.te = te; e.ce = ce; e.idx = idx; e.v = v;
    e.npc = npc; e.tag = tag; e.cn = cn; e.bz = bz;
    expq.push_back(e);
  endfunction

  function automatic void exp_sweep(input int first_c, input int from, input int to);
    for (int i = from; i <= to; i++)
      exp_push(first_c + i - from, 1'b1, 1'b1, IW'(i), 1'b0, '0, '0, 2'b01, i != TS - 1);
  endfunction

  task automatic idle_inputs();
    bif.flush_req = 1'b0;
    bif.cnt_push  = 1'b0;
    bif.cnt_idx   = '0;
    bif.cnt_prev  = '0;
    bif.cnt_taken = 1'b0;
    bif.tgt_valid = 1'b0;
    bif.tgt_idx   = '0;
    bif.tgt_addr  = '0;
    bif.tgt_tag   = '0;
  endtask

  task automatic drive_cnt(input logic [IW-1:0] idx, input logic [1:0] prev, input bit tk);
    bif.cnt_push  = 1'b1;
    bif.cnt_idx   = idx;
    bif.cnt_prev  = prev;
    bif.cnt_taken = tk;
  endtask

  task automatic drive_tgt(input logic [IW-1:0] idx, input logic [PW-1:0] addr, input logic [TW-1:0] tag);
    bif.tgt_valid = 1'b1;
    bif.tgt_idx   = idx;
    bif.tgt_addr  = addr;
    bif.tgt_tag   = tag;
  endtask

  // Write monitor: every observed write must match the head of the scoreboard at its cycle.
  always @(negedge clk) begin
    if (nrst) begin
      while (expq.size() > 0 && expq[0].c < cyc) begin
        check("missing_write_cycle", 64'(cyc), 64'(expq[0].c));
        void'(expq.pop_front());
      end
      if (bif.wr_tgt_en || bif.wr_cnt_en) begin
        if (expq.size() == 0) begin
          check("unexpected_write", {bif.wr_tgt_en, bif.wr_cnt_en}, 64'd0);
        end else begin
          mon_e = expq.pop_front();
          check("wr_cycle", 64'(cyc), 64'(mon_e.c));
          check("wr_tgt_en", bif.wr_tgt_en, mon_e.te);
          check("wr_cnt_en", bif.wr_cnt_en, mon_e.ce);
          check("wr_idx", bif.wr_idx, mon_e.idx);
          check("busy_at_wr", bif.busy, mon_e.bz);
          if (mon_e.te) begin
            check("wr_valid", bif.wr_valid, mon_e.v);
            check("wr_npc", bif.wr_npc, mon_e.npc);
            check("wr_tag", bif.wr_tag, mon_e.tag);
          end
          if (mon_e.ce)
            check("wr_cnt", bif.wr_cnt, mon_e.cn);
        end
      end
    end
  end

  initial begin
    int e0;
    int f;
    logic [1:0] pv [4];
    bit         tk [4];
    pv = '{2'b00, 2'b01, 2'b10, 2'b11};
    tk = '{1'b1, 1'b1, 1'b1, 1'b0};

    idle_inputs();
    nrst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", bif.busy, 1'b1);
    check("rst_wr_tgt_en", bif.wr_tgt_en, 1'b0);
    check("rst_wr_cnt_en", bif.wr_cnt_en, 1'b0);
    check("rst_cnt_ovf", bif.cnt_ovf, 1'b0);
    check("rst_tgt_ready", bif.tgt_ready, 1'b0);
    check("rst_wr_idx", bif.wr_idx, '0);

    // Initial sweep
    nrst = 1'b1;
    exp_sweep(cyc + 1, 0, TS - 1);
    repeat (TS) @(negedge clk);
    check("run_busy_low", bif.busy, 1'b0);
    check("run_tgt_ready", bif.tgt_ready, 1'b1);

    // Counter updates back-to-back at idx 5
    drive_cnt(9'd5, 2'b00, 1'b1);
    exp_push(cyc + 2, 1'b0, 1'b1, 9'd5, 1'b0, '0, '0, cnt_ref(2'b00, 1'b1), 1'b0);
    @(negedge clk);
    drive_cnt(9'd5, 2'b01, 1'b1);
    exp_push(cyc + 2, 1'b0, 1'b1, 9'd5, 1'b0, '0, '0, cnt_ref(2'b01, 1'b1), 1'b0);
    @(negedge clk);
    drive_cnt(9'd5, 2'b11, 1'b0);
    exp_push(cyc + 2, 1'b0, 1'b1, 9'd5, 1'b0, '0, '0, cnt_ref(2'b11, 1'b0), 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    // Target install
    drive_tgt(9'h1A3, 32'h0000_4C20, 21'h12345);
    #1 check("tgt_ready_run", bif.tgt_ready, 1'b1);
    exp_push(cyc + 1, 1'b1, 1'b0, 9'h1A3, 1'b1, 32'h0000_4C20, 21'h12345, 2'b00, 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    // Same index: counter pop rides along with the install
    drive_cnt(9'h040, 2'b10, 1'b1);
    @(negedge clk);
    idle_inputs();
    drive_tgt(9'h040, 32'h0000_8000, 21'h0ABCD);
    exp_push(cyc + 1, 1'b1, 1'b1, 9'h040, 1'b1, 32'h0000_8000, 21'h0ABCD,
             cnt_ref(2'b10, 1'b1), 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    // Overflow: target stream at other indices stalls the FIFO
    e0 = cyc + 1;
    for (int j = 0; j < 6; j++) begin
      if (j <= 2) check("ovf_not_yet", bif.cnt_ovf, 1'b0);
      else        check("ovf_set", bif.cnt_ovf, 1'b1);
      idle_inputs();
      drive_tgt(IW'(100 + j), 32'h1000 + 32'(j * 4), TW'(j + 1));
      exp_push(e0 + j, 1'b1, 1'b0, IW'(100 + j), 1'b1, 32'h1000 + 32'(j * 4), TW'(j + 1),
               2'b00, 1'b0);
      if (j < 4) drive_cnt(9'd7, pv[j], tk[j]);
      @(negedge clk);
    end
    idle_inputs();
    exp_push(e0 + 6, 1'b0, 1'b1, 9'd7, 1'b0, '0, '0, cnt_ref(pv[0], tk[0]), 1'b0);
    exp_push(e0 + 7, 1'b0, 1'b1, 9'd7, 1'b0, '0, '0, cnt_ref(pv[1], tk[1]), 1'b0);
    repeat (4) @(negedge clk);
    check("ovf_sticky", bif.cnt_ovf, 1'b1);

    // Flush in RUN with two buffered updates
    drive_tgt(9'd200, 32'h2000, 21'h1);
    drive_cnt(9'd9, 2'b00, 1'b1);
    exp_push(cyc + 1, 1'b1, 1'b0, 9'd200, 1'b1, 32'h2000, 21'h1, 2'b00, 1'b0);
    @(negedge clk);
    drive_tgt(9'd201, 32'h2004, 21'h2);
    drive_cnt(9'd10, 2'b01, 1'b0);
    exp_push(cyc + 1, 1'b1, 1'b0, 9'd201, 1'b1, 32'h2004, 21'h2, 2'b00, 1'b0);
    @(negedge clk);
    idle_inputs();
    drive_tgt(9'd202, 32'h2008, 21'h3);
    bif.flush_req = 1'b1;
    f = cyc + 1;
    #1 check("tgt_ready_flush", bif.tgt_ready, 1'b0);
    exp_sweep(f + 1, 0, 299);
    @(negedge clk);
    idle_inputs();
    check("busy_after_flush", bif.busy, 1'b1);

    // Flush again at sweep index 300
    repeat (300) @(negedge clk);
    bif.flush_req = 1'b1;
    exp_sweep(cyc + 1, 0, TS - 1);
    @(negedge clk);
    idle_inputs();
    repeat (TS + 2) @(negedge clk);
    check("busy_after_resweep", bif.busy, 1'b0);
    check("ovf_survives_flush", bif.cnt_ovf, 1'b1);

    // Asynchronous reset in the middle of a transfer
    drive_tgt(9'h055, 32'h0000_ABC0, 21'h1F00F);
    drive_cnt(9'h066, 2'b01, 1'b1);
    exp_push(cyc + 1, 1'b1, 1'b0, 9'h055, 1'b1, 32'h0000_ABC0, 21'h1F00F, 2'b00, 1'b0);
    @(negedge clk);
    idle_inputs();
    #2 nrst = 1'b0;
    expq.delete();
    #1;
    check("arst_wr_tgt_en", bif.wr_tgt_en, 1'b0);
    check("arst_wr_cnt_en", bif.wr_cnt_en, 1'b0);
    check("arst_wr_idx", bif.wr_idx, '0);
    check("arst_wr_valid", bif.wr_valid, 1'b0);
    check("arst_wr_npc", bif.wr_npc, '0);
    check("arst_wr_tag", bif.wr_tag, '0);
    check("arst_wr_cnt", bif.wr_cnt, 2'b00);
    check("arst_busy", bif.busy, 1'b1);
    check("arst_ovf", bif.cnt_ovf, 1'b0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    exp_sweep(cyc + 1, 0, TS - 1);
    repeat (TS + 3) @(negedge clk);
    check("final_busy", bif.busy, 1'b0);
    check("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
